// File: rtl/ysyx_22050039_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// the reset PC and the fetch FSM state encoding.
package ysyx_22050039_fetch_unit_pkg;

    localparam int          XLEN_DEF     = 64;
    localparam int          INST_LEN_DEF = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

    // Fetch FSM: IDLE only exists for the first cycle after reset.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    // Instruction words are 4-byte aligned; any low address bit set is a fault.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22050039_fetch_pc.sv
// Architectural PC register of the fetch stage. Produces the PC that the
// next fetch will use (redirect target, sequential pc+4, or unchanged) and
// flags it when it is not word aligned.
module ysyx_22050039_fetch_pc
    import ysyx_22050039_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF[XLEN-1:0]
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_we,
    input  logic            advance,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] next_pc,
    output logic            next_misaligned
);

    logic [XLEN-1:0] pc_q;

    // Next-PC mux: a redirect always wins over sequential advance.
    always_comb begin
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (advance) begin
            next_pc = pc_q + XLEN'(4);
        end else begin
            next_pc = pc_q;
        end
        next_misaligned = is_misaligned(next_pc[1:0]);
    end

    // PC register; loads the mux output whenever the control asks for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (pc_we) begin
            pc_q <= next_pc;
        end
    end

endmodule

// File: rtl/ysyx_22050039_fetch_unit.sv
// Instruction fetch stage feeding decode. One word fetch is outstanding at a
// time; a redirect while a fetch is in flight marks it killed so its response
// is dropped. Misaligned PCs never reach memory and are delivered as faults.
// Optional performance counters are built when YSYX_22050039_FETCH_PERF_EN
// is defined.
module ysyx_22050039_fetch_unit
    import ysyx_22050039_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              INST_LEN = INST_LEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF[XLEN-1:0]
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [INST_LEN-1:0] imem_resp_data,
    input  logic                imem_resp_err,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_LEN-1:0] inst,
    output logic [XLEN-1:0]     inst_pc,
    output logic                fetch_fault,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc
`ifdef YSYX_22050039_FETCH_PERF_EN
    ,
    output logic [63:0]         perf_fetch_cnt,
    output logic [63:0]         perf_stall_cnt
`endif
);

    fetch_state_e    state_q, state_d;
    logic            kill_q;
    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;
    logic            pc_we, advance;
    logic            enter, accept, resp_drop, kill_set;

    ysyx_22050039_fetch_pc #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk             (clk),
        .rst_n           (rst),
        .pc_we           (pc_we),
        .advance         (advance),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .next_pc         (next_pc),
        .next_misaligned (next_misaligned)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; "enter" restarts fetching at next_pc, skipping
    // memory entirely when that PC is misaligned.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        if (enter) begin
            state_d = next_misaligned ? ST_HOLD : ST_REQ;
        end else begin
            case (state_q)
                ST_REQ:  if (imem_req_ready) state_d = ST_WAIT;
                ST_WAIT: if (accept)         state_d = ST_HOLD;
                default: state_d = state_q;
            endcase
        end
    end

    // Output and control decode from the current state.
    always_comb begin
        imem_req_valid = (state_q == ST_REQ);
        inst_valid     = (state_q == ST_HOLD);
        advance        = (state_q == ST_HOLD) && inst_ready;
        pc_we          = redirect_valid || advance;
        resp_drop      = (state_q == ST_WAIT) && imem_resp_valid && (kill_q || redirect_valid);
        accept         = (state_q == ST_WAIT) && imem_resp_valid && !kill_q && !redirect_valid;
        enter          = (state_q == ST_IDLE) || resp_drop ||
                         ((state_q == ST_HOLD) && (inst_ready || redirect_valid));
        kill_set       = redirect_valid && !resp_drop &&
                         ((state_q == ST_REQ) || (state_q == ST_WAIT));
    end

    // Request address, kill flag and the instruction presented to decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kill_q        <= 1'b0;
            imem_req_addr <= '0;
            inst          <= '0;
            inst_pc       <= '0;
            fetch_fault   <= 1'b0;
        end else begin
            if (enter) begin
                kill_q <= 1'b0;
            end else if (kill_set) begin
                kill_q <= 1'b1;
            end

            if (enter) begin
                imem_req_addr <= next_pc;
                if (next_misaligned) begin
                    inst        <= '0;
                    inst_pc     <= next_pc;
                    fetch_fault <= 1'b1;
                end
            end else if (accept) begin
                inst        <= imem_resp_data;
                inst_pc     <= imem_req_addr;
                fetch_fault <= imem_resp_err;
            end
        end
    end

`ifdef YSYX_22050039_FETCH_PERF_EN
    // Delivered-instruction and memory-stall counters, free-running with wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (inst_valid && inst_ready) begin
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            end
            if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22050039_fetch_unit.sv
// Self-checking bench for ysyx_22050039_fetch_unit: directed scenarios then a
// randomized phase, all checked against an architectural reference model
// (expected PC stream) and a behavioural instruction memory.
module tb_ysyx_22050039_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        fetch_fault;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
`ifdef YSYX_22050039_FETCH_PERF_EN
    logic [63:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_22050039_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .fetch_fault     (fetch_fault),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
`ifdef YSYX_22050039_FETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    // Per-cycle drive policy.
    logic        ready_d = 1'b0, inst_ready_d = 1'b0, redir_v_d = 1'b0;
    logic [63:0] redir_pc_d = 64'd0;
    int          lat_d = 0;
    bit          stray_en = 1'b0, stray_force = 1'b0;

    // Memory model and reference state.
    bit          mem_pending = 1'b0;
    logic [63:0] mem_addr = 64'd0;
    int          mem_wait = 0;
    logic [63:0] ref_pc = RST_PC;
    bit          hs_seen = 1'b0;
    logic [63:0] hs_addr = 64'd0;
    int          dec_hs = 0;
    int          stall_run = 0;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ 32'h8000_0413;
    endfunction

    function automatic logic err_at(input logic [63:0] a);
        return a[6:2] == 5'd5;
    endfunction

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        if ($urandom_range(0, 15) == 0) t = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 1) * 4);
        else                            t = RST_PC + 64'($urandom_range(0, 255) * 4);
        if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive after the rising edge, sample and model at the falling edge.
    task automatic cycle();
        logic mis;
        @(posedge clk);
        #1;
        if (mem_pending && mem_wait == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(mem_addr);
            imem_resp_err   = err_at(mem_addr);
        end else if (!mem_pending && (stray_force || (stray_en && $urandom_range(0, 7) == 0))) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = stray_force ? 32'hDEAD_BEEF : $urandom;
            imem_resp_err   = 1'b1;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'd0;
            imem_resp_err   = 1'b0;
        end
        imem_req_ready = ready_d;
        inst_ready     = inst_ready_d;
        redirect_valid = redir_v_d;
        redirect_pc    = redir_pc_d;
        @(negedge clk);
        if (rst) begin
            if (mem_pending) begin
                if (imem_resp_valid) mem_pending = 1'b0;
                else                 mem_wait--;
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_aligned", 64'(imem_req_addr[1:0]), 64'd0);
                hs_seen     = 1'b1;
                hs_addr     = imem_req_addr;
                mem_pending = 1'b1;
                mem_addr    = imem_req_addr;
                mem_wait    = lat_d;
            end
            if (inst_valid) begin
                mis = ref_pc[1:0] != 2'b00;
                chk("inst_pc", inst_pc, ref_pc);
                chk("inst", 64'(inst), mis ? 64'd0 : 64'(mem_data(ref_pc)));
                chk("fault", 64'(fetch_fault), 64'(mis || err_at(ref_pc)));
            end
            if (inst_valid && inst_ready) begin
                ref_pc    = redirect_valid ? redirect_pc : ref_pc + 64'd4;
                dec_hs++;
                stall_run = 0;
            end else begin
                if (redirect_valid) ref_pc = redirect_pc;
                stall_run++;
            end
        end
    endtask

    task automatic wait_inst(input string tag);
        int i = 0;
        inst_ready_d = 1'b0;
        do begin
            cycle();
            i++;
        end while (!inst_valid && i < 60);
        chk(tag, 64'(inst_valid), 64'd1);
    endtask

    task automatic wait_req(input string tag);
        int i = 0;
        hs_seen = 1'b0;
        do begin
            cycle();
            i++;
        end while (!hs_seen && i < 60);
        chk(tag, 64'(hs_seen), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        chk({tag, "_req_addr"},  imem_req_addr,       64'd0);
        chk({tag, "_inst_valid"},64'(inst_valid),     64'd0);
        chk({tag, "_inst"},      64'(inst),           64'd0);
        chk({tag, "_inst_pc"},   inst_pc,             64'd0);
        chk({tag, "_fault"},     64'(fetch_fault),    64'd0);
`ifdef YSYX_22050039_FETCH_PERF_EN
        chk({tag, "_perf_fetch"}, perf_fetch_cnt, 64'd0);
        chk({tag, "_perf_stall"}, perf_stall_cnt, 64'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        bit  req_chk;
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0; imem_resp_err = 1'b0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
        #2 rst = 1'b0;
        #2 chk_reset_outputs("reset");

        // Zero-wait first fetch: instruction visible in the third cycle.
        @(negedge clk);
        rst = 1'b1; ref_pc = RST_PC;
        ready_d = 1'b1; lat_d = 0; inst_ready_d = 1'b0;
        n = 0; req_chk = 1'b0;
        do begin
            cycle();
            n++;
            if (imem_req_valid && !req_chk) begin
                chk("t1_req_addr", imem_req_addr, RST_PC);
                req_chk = 1'b1;
            end
        end while (!inst_valid && n < 20);
        chk("t1_latency", 64'(n), 64'd3);
        chk("t1_inst", 64'(inst), 64'h0000_0413);

        // Decode stalls five cycles: held outputs stable, memory idle.
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_valid", 64'(inst_valid), 64'd1);
            chk("t2_inst_pc", inst_pc, RST_PC);
            chk("t2_inst", 64'(inst), 64'h0000_0413);
            chk("t2_no_req", 64'(imem_req_valid), 64'd0);
        end
        lat_d = 2;
        inst_ready_d = 1'b1;
        cycle();
        wait_req("t2_req_seen");
        chk("t2_next_addr", hs_addr, RST_PC + 64'd4);

        // Redirect while waiting; the late response must be discarded.
        redir_v_d = 1'b1; redir_pc_d = 64'h8000_0100;
        cycle();
        redir_v_d = 1'b0; lat_d = 0;
        wait_req("t3_req_seen");
        chk("t3_redirect_addr", hs_addr, 64'h8000_0100);
        wait_inst("t3_inst_seen");
        chk("t3_inst_pc", inst_pc, 64'h8000_0100);

        // Misaligned redirect on the handshake: fault delivered without a request.
        inst_ready_d = 1'b1; redir_v_d = 1'b1; redir_pc_d = 64'h8000_0102;
        cycle();
        redir_v_d = 1'b0; inst_ready_d = 1'b0; hs_seen = 1'b0;
        cycle();
        chk("t4_valid", 64'(inst_valid), 64'd1);
        chk("t4_fault", 64'(fetch_fault), 64'd1);
        chk("t4_inst", 64'(inst), 64'd0);
        chk("t4_inst_pc", inst_pc, 64'h8000_0102);
        chk("t4_no_req", 64'(hs_seen), 64'd0);

        // Bus error on one fetch, clean fetch right after it.
        inst_ready_d = 1'b1; redir_v_d = 1'b1; redir_pc_d = 64'h8000_0014;
        cycle();
        redir_v_d = 1'b0;
        wait_inst("t5_err_seen");
        chk("t5_err_fault", 64'(fetch_fault), 64'd1);
        chk("t5_err_pc", inst_pc, 64'h8000_0014);
        inst_ready_d = 1'b1;
        cycle();
        wait_inst("t5_ok_seen");
        chk("t5_ok_fault", 64'(fetch_fault), 64'd0);
        chk("t5_ok_pc", inst_pc, 64'h8000_0018);

        // Reset while waiting for memory; stray responses afterwards are ignored.
        lat_d = 3; inst_ready_d = 1'b1;
        cycle();
        inst_ready_d = 1'b0;
        wait_req("t6_req_seen");
        cycle();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("t6_midreset");
        mem_pending = 1'b0;
        stray_force = 1'b1; ready_d = 1'b0;
        cycle();
        cycle();
        rst = 1'b1; ref_pc = RST_PC;
        cycle();
        cycle();
        stray_force = 1'b0; ready_d = 1'b1; lat_d = 0;
        wait_req("t6_restart_seen");
        chk("t6_restart_addr", hs_addr, RST_PC);
        wait_inst("t6_inst_seen");
        chk("t6_inst", 64'(inst), 64'h0000_0413);

        // Randomized traffic against the reference model.
        stray_en = 1'b1; dec_hs = 0; stall_run = 0;
        for (int c = 0; c < 3000; c++) begin
            ready_d      = ($urandom_range(0, 3) != 0);
            inst_ready_d = ($urandom_range(0, 2) != 0);
            lat_d        = $urandom_range(0, 3);
            redir_v_d    = ($urandom_range(0, 11) == 0);
            redir_pc_d   = rand_target();
            cycle();
            if (stall_run == 200) chk("watchdog_stall", 64'(stall_run), 64'd0);
        end
        chk("rand_progress", 64'(dec_hs > 300), 64'd1);

`ifdef YSYX_22050039_FETCH_PERF_EN
        // Four zero-wait fetches: two memory cycles each.
        redir_v_d = 1'b0; stray_en = 1'b0; ready_d = 1'b1; lat_d = 0; inst_ready_d = 1'b1;
        rst = 1'b0;
        #2;
        rst = 1'b1; ref_pc = RST_PC; mem_pending = 1'b0; dec_hs = 0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (dec_hs < 4 && n < 40);
        @(posedge clk);
        #1;
        chk("perf_fetch_cnt", perf_fetch_cnt, 64'd4);
        chk("perf_stall_cnt", perf_stall_cnt, 64'd8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ysyx_22050039_fetch_unit.md
Name: ysyx_22050039_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decode stage.
- Holds the architectural PC and issues one word fetch at a time to instruction memory over valid/ready request/response channels.
- Presents each fetched instruction and its PC to decode with a valid/ready handshake.
- Accepts a PC redirect (jump/branch target, i.e. decode's pc_wen plus target) and discards any stale in-flight fetch.

Parameters:
XLEN, 64, width of PC and addresses
INST_LEN, 32, instruction width
RESET_PC, 64'h8000_0000, PC loaded on reset

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (registered)
imem_resp_valid  in  1  response valid (always accepted)
imem_resp_data  in  INST_LEN  fetched word
imem_resp_err  in  1  bus error on this response
inst_valid  out  1  instruction presented to decode
inst_ready  in  1  decode accepts instruction
inst  out  INST_LEN  instruction word
inst_pc  out  XLEN  PC of inst
fetch_fault  out  1  inst carries a fault (misaligned or bus error)
redirect_valid  in  1  PC write request (pc_wen)
redirect_pc  in  XLEN  redirect target

Behaviour:
- Reset (rst low, async): pc=RESET_PC; state=IDLE; kill=0; imem_req_valid=0; imem_req_addr=0; inst_valid=0; inst=0; inst_pc=0; fetch_fault=0.
- States:
  - IDLE: always goes to REQ on the next clk after reset release. req_addr<=pc.
  - REQ: imem_req_valid=1. Address and valid stay stable until req_valid&req_ready. On handshake go to WAIT.
  - WAIT: on imem_resp_valid:
    - kill=1: drop the response; kill<=0; req_addr<=pc; go to REQ.
    - kill=0: inst<=resp_data; inst_pc<=req_addr; fetch_fault<=resp_err; go to HOLD.
  - HOLD: inst_valid=1; outputs stable until inst_ready. On inst_ready: pc<=redirect_valid ? redirect_pc : pc+4 (XLEN wrap); go to REQ with req_addr<=new pc.
- Minimum latency: REQ→WAIT→HOLD, 3 cycles per instruction with zero-wait memory. There is no prefetch, so at most one request is outstanding.
- Redirect handling:
  - In HOLD, redirect_valid is consumed on the inst handshake.
  - Redirect in HOLD without inst_ready: held instruction dropped (inst_valid low next cycle); pc<=redirect_pc; go to REQ.
  - Redirect in REQ or WAIT: pc<=redirect_pc; kill<=1. The pending request still completes per protocol and its response is discarded.
  - Redirect in WAIT in the same cycle as the response: response discarded; go to REQ at redirect_pc.
  - Redirect in IDLE: pc<=redirect_pc.
  - Multiple redirects: the last one wins.
- Misalignment (pc[1:0]!=0 on entry to REQ): no memory request is issued. Go directly to HOLD with inst=0, inst_pc=pc, fetch_fault=1.
- Faulted instructions handshake normally; the next PC is computed as usual.
- imem_resp_valid outside WAIT is ignored.
- Reset mid-operation: immediate return to reset values; no response is awaited after reset.

Optional Feature:
- Macro: YSYX_22050039_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt (64) and perf_stall_cnt (64), both reset to 0.
  - perf_fetch_cnt increments on each inst_valid&inst_ready.
  - perf_stall_cnt increments on each cycle in REQ or WAIT.
  - Both wrap at 2^64.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header: fetch state encoding (IDLE/REQ/WAIT/HOLD, 2 bits), RESET_PC default, INST_LEN and XLEN defaults.
- One natural sub-module, ysyx_22050039_fetch_pc: PC register with async active-low reset, next-PC mux (pc+4 vs redirect_pc) and misalignment check.

Test Plan:
- Reset release, memory ready=1, one-cycle response, data 32'h00000413 → req_addr=0x80000000; inst_valid at cycle 3 with inst_pc=0x80000000; next request at 0x80000004.
- Decode holds inst_ready=0 for 5 cycles → inst, inst_pc and fetch_fault stable; no new request issued.
- Redirect to 0x80000100 asserted in WAIT, response arrives 2 cycles later → response dropped; next req_addr=0x80000100; only that instruction reaches decode.
- Redirect to 0x80000102 on the inst handshake → no memory request; inst_valid with fetch_fault=1, inst=0, inst_pc=0x80000102.
- Response with imem_resp_err=1 → fetch_fault=1 on that instruction; following fetch at pc+4 with fault=0.
- Reset asserted while in WAIT → all outputs zero immediately; late response ignored; restart at 0x80000000.
- With YSYX_22050039_FETCH_PERF_EN defined: 4 zero-wait fetches → perf_fetch_cnt=4 and perf_stall_cnt=8.
